// File: rtl/intr_ctrl.sv
// intr_ctrl: two-source interrupt controller.
// Each external line is synchronised and edge-detected into a pending flag.
// The highest-priority pending source (intr1 over intr2) is presented to the
// CPU as irq plus a jump vector. A request is held until ack, and the source
// is then tracked as in-service until reti. Nesting is not supported.
module intr_ctrl #(
    parameter int unsigned        VEC_W = 10,
    parameter logic [VEC_W-1:0]   VEC1  = 10'd4,
    parameter logic [VEC_W-1:0]   VEC2  = 10'd8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             intr1,
    input  logic             intr2,
    input  logic             en,
    input  logic             ack,
    input  logic             reti,
    output logic             irq,
    output logic [VEC_W-1:0] vector,
    output logic [1:0]       pending,
    output logic [1:0]       in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_n;

    // Synchroniser stages and previous-value flops; bit0 = intr1, bit1 = intr2
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] p;
    logic [1:0] edges;

    // Source chosen when leaving IDLE, one-hot, frozen through REQ/SERVICE
    logic [1:0] sel;

    logic       take;
    logic       ack_req;
    logic       reti_svc;
    logic [1:0] clr;

    // Rising-edge detect and handshake qualifiers for the current state
    always_comb begin
        edges    = s2 & ~p;
        take     = (state == IDLE) && en && (pending != 2'b00);
        ack_req  = (state == REQ) && ack;
        reti_svc = (state == SERVICE) && reti;
        clr      = ack_req ? sel : 2'b00;
    end

    // Two-flop synchroniser plus previous-value flop for both lines
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            p  <= '0;
        end else begin
            s1 <= {intr2, intr1};
            s2 <= s1;
            p  <= s2;
        end
    end

    // Pending flags: edges set, ack of the selected source clears; set wins
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr) | edges;
        end
    end

    // Latch the winning source and its vector as the request is raised
    always_ff @(posedge clk) begin
        if (reset) begin
            sel    <= '0;
            vector <= '0;
        end else if (take) begin
            if (pending[0]) begin
                sel    <= 2'b01;
                vector <= VEC1;
            end else begin
                sel    <= 2'b10;
                vector <= VEC2;
            end
        end
    end

    // In-service tracking: set on ack, cleared on reti
    always_ff @(posedge clk) begin
        if (reset) begin
            in_service <= '0;
        end else if (ack_req) begin
            in_service <= sel;
        end else if (reti_svc) begin
            in_service <= '0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next-state logic; en only gates the IDLE -> REQ decision
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (take)     state_n = REQ;
            REQ:     if (ack)      state_n = SERVICE;
            SERVICE: if (reti)     state_n = IDLE;
            default:               state_n = IDLE;
        endcase
    end

    // FSM outputs: request is asserted only while waiting for ack
    always_comb begin
        irq = (state == REQ);
    end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Two-source interrupt controller between the external interrupt lines (intr1, intr2) and the monocycle CPU core. It synchronises each line, turns rising edges into pending requests, and picks the higher-priority pending source. It then drives a request/acknowledge handshake towards the CPU, supplying a jump vector. It tracks the in-service source until the CPU signals return-from-interrupt.

## Interface
- VEC_W, 10: width of the jump vector (PC width).
- VEC1, 10'd4: vector address for intr1.
- VEC2, 10'd8: vector address for intr2.

- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- intr1  input  1  external interrupt line 1, asynchronous, rising-edge significant; highest priority.
- intr2  input  1  external interrupt line 2, asynchronous, rising-edge significant.
- en  input  1  global interrupt enable from CPU.
- ack  input  1  CPU has taken the jump to vector this cycle.
- reti  input  1  CPU executed return-from-interrupt this cycle.
- irq  output  1  interrupt request to CPU.
- vector  output  VEC_W  jump address, valid while irq=1.
- pending  output  2  bit0 = intr1, bit1 = intr2 latched, not yet acknowledged.
- in_service  output  2  one-hot source currently being serviced, 0 when none.

## Operation
- Per line: 2-flop synchroniser (s1, s2) plus previous-value flop (p); edge = s2 & ~p.
- Edge on source i sets pending[i].
  - Pending is a flag, not a counter; repeated edges while set are absorbed.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: irq=0. If en=1 and pending≠0, latch sel = intr1 if pending[0] else intr2, latch vector = VEC1/VEC2 accordingly, go to REQ.
  - REQ: irq=1, vector and sel frozen. ack=1 → clear pending[sel], set in_service to one-hot sel, go to SERVICE. en falling in REQ does not withdraw the request; irq holds until ack.
  - SERVICE: irq=0. reti=1 → in_service=0, go to IDLE. No nesting: new edges only set pending.
- Ignored inputs:
  - ack outside REQ.
  - reti outside SERVICE.
- Simultaneous edge and ack clear on the same source: set wins, so pending stays 1 (new event).
- Both sources pending in IDLE: intr1 served first; intr2 stays pending and is served after reti.
- vector holds its last value when irq=0; 0 after reset.

## Timing
- Reset values: irq=0, vector=0, pending=2'b00, in_service=2'b00, FSM=IDLE, s1=s2=p=0.
- A line held high across reset release is therefore seen as one edge.
- Edge latency: line first sampled high at edge E0 → pending[i]=1 after E2.
- With en=1 in IDLE, irq=1 and vector valid after E3.
- ack sampled high at edge → after that edge: irq=0, pending[sel]=0, in_service set.
- reti sampled high at edge → in_service=0 after that edge.
- The earliest next irq comes one cycle later, since IDLE re-evaluates pending.
- Pulses shorter than one clock period may be missed; the sender must hold ≥1 full cycle.
- Line must return low ≥1 cycle (after synchronisation) to register another edge.
- Reset mid-operation (any state) aborts: all outputs return to reset values on the next edge, and pending requests are discarded.

## Test plan
- intr1 rises before edge E0, en=1, ack=0 → pending=01 after E2; irq=1, vector=10'd4 after E3; irq stays 1 for 5 cycles with no ack.
- From that REQ state, pulse ack 1 cycle → irq=0, pending=00, in_service=01 next edge; then pulse reti → in_service=00, state IDLE.
- intr1 and intr2 rise together, en=1 → vector=4 first. After ack+reti, irq reasserts with vector=10'd8 one cycle after reti; pending=10 throughout the first service.
- en=0, intr2 rises → pending=10, irq stays 0. Raise en → irq=1, vector=8 on the next edge.
- During SERVICE of intr1, intr1 falls and rises again → pending=01 and irq=0 until reti; irq=1 one cycle after reti.
- Assert reset for 1 cycle while in REQ with pending=11 → all outputs 0. intr1 still high at release → pending=01 three edges later. Stray ack/reti in IDLE cause no change.
